// File: rtl/axi_pkg.sv
// Shared AXI/ACE encodings and the responder state encoding.
package axi_pkg;

  typedef enum logic [1:0] {
    BURST_FIXED = 2'b00,
    BURST_INCR  = 2'b01,
    BURST_WRAP  = 2'b10
  } burst_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam logic [3:0] SNOOP_INVALIDATE = 4'hd;
  localparam int         LINE_BYTES       = 64;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_R_BURST,
    ST_W_BURST,
    ST_SNOOP,
    ST_W_RESP
  } state_e;

endpackage

// File: rtl/axi_burst_addr.sv
// Combinational AXI next-beat address for FIXED/INCR/WRAP bursts.
module axi_burst_addr
  import axi_pkg::*;
#(
  parameter int ADDR_WIDTH = 64
) (
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [7:0]            len,
  input  logic [2:0]            size,
  input  logic [1:0]            burst,
  output logic [ADDR_WIDTH-1:0] next_addr
);

  logic [ADDR_WIDTH-1:0] incr, span, mask, inc_addr;
  logic                  wrap_ok;

  always_comb begin
    incr     = ADDR_WIDTH'(1) << size;
    span     = (ADDR_WIDTH'(len) + ADDR_WIDTH'(1)) << size;
    mask     = span - ADDR_WIDTH'(1);
    inc_addr = addr + incr;
    // illegal wrap lengths degrade to INCR rather than faulting
    wrap_ok  = (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
    next_addr = addr;
    case (burst)
      BURST_INCR: next_addr = inc_addr;
      BURST_WRAP: next_addr = wrap_ok ? ((addr & ~mask) | (inc_addr & mask)) : inc_addr;
      default:    next_addr = addr;
    endcase
  end

endmodule

// File: rtl/axi_mem_responder.sv
// AXI4 slave backed by an on-chip word RAM; issues an invalidate snoop after each write.
module axi_mem_responder
  import axi_pkg::*;
#(
  parameter int                    ID_WIDTH   = 13,
  parameter int                    ADDR_WIDTH = 64,
  parameter int                    DATA_WIDTH = 64,
  parameter int                    MEM_WORDS  = 4096,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 64'h0000_0000_8000_0000
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [ID_WIDTH-1:0]     s_awid,
  input  logic [ADDR_WIDTH-1:0]   s_awaddr,
  input  logic [7:0]              s_awlen,
  input  logic [2:0]              s_awsize,
  input  logic [1:0]              s_awburst,
  input  logic                    s_awvalid,
  output logic                    s_awready,
  input  logic [DATA_WIDTH-1:0]   s_wdata,
  input  logic [DATA_WIDTH/8-1:0] s_wstrb,
  input  logic                    s_wlast,
  input  logic                    s_wvalid,
  output logic                    s_wready,
  output logic [ID_WIDTH-1:0]     s_bid,
  output logic [1:0]              s_bresp,
  output logic                    s_bvalid,
  input  logic                    s_bready,
  input  logic [ID_WIDTH-1:0]     s_arid,
  input  logic [ADDR_WIDTH-1:0]   s_araddr,
  input  logic [7:0]              s_arlen,
  input  logic [2:0]              s_arsize,
  input  logic [1:0]              s_arburst,
  input  logic                    s_arvalid,
  output logic                    s_arready,
  output logic [ID_WIDTH-1:0]     s_rid,
  output logic [DATA_WIDTH-1:0]   s_rdata,
  output logic [1:0]              s_rresp,
  output logic                    s_rlast,
  output logic                    s_rvalid,
  input  logic                    s_rready,
  output logic [ADDR_WIDTH-1:0]   ac_addr,
  output logic [3:0]              ac_snoop,
  output logic                    ac_valid,
  input  logic                    ac_ready,
  input  logic                    snoop_en
);

  localparam int NUM_LANES = DATA_WIDTH / 8;
  localparam int IDX_W     = $clog2(MEM_WORDS);
  localparam int LANE_SH   = $clog2(NUM_LANES);

  typedef struct packed {
    logic [ID_WIDTH-1:0]   id;
    logic [ADDR_WIDTH-1:0] addr;
    logic [ADDR_WIDTH-1:0] start;
    logic [7:0]            len;
    logic [2:0]            size;
    logic [1:0]            burst;
  } txn_t;

  state_e                state, state_nx;
  txn_t                  txn;
  logic [7:0]            cnt;
  logic [1:0]            resp_q;
  logic [ADDR_WIDTH-1:0] next_addr, off;
  logic [IDX_W-1:0]      idx;
  logic                  in_win, at_len, w_hs, r_hs;

  logic [NUM_LANES-1:0][7:0] mem [MEM_WORDS];

  axi_burst_addr #(.ADDR_WIDTH(ADDR_WIDTH)) u_next (
    .addr      (txn.addr),
    .len       (txn.len),
    .size      (txn.size),
    .burst     (txn.burst),
    .next_addr (next_addr)
  );

  assign off    = txn.addr - BASE_ADDR;
  assign idx    = off[IDX_W+LANE_SH-1:LANE_SH];
  assign in_win = (txn.addr >= BASE_ADDR) && ((off >> LANE_SH) < ADDR_WIDTH'(MEM_WORDS));
  assign at_len = (cnt == txn.len);

  // AR is held off while AW is offered so a simultaneous pair is served write-first
  assign s_awready = (state == ST_IDLE);
  assign s_arready = (state == ST_IDLE) && !s_awvalid;
  assign s_wready  = (state == ST_W_BURST);
  assign s_rvalid  = (state == ST_R_BURST);
  assign s_bvalid  = (state == ST_W_RESP);
  assign ac_valid  = (state == ST_SNOOP);

  assign w_hs = s_wvalid && s_wready;
  assign r_hs = s_rvalid && s_rready;

  assign s_rid    = txn.id;
  assign s_bid    = txn.id;
  assign s_bresp  = resp_q;
  assign s_rdata  = (s_rvalid && in_win) ? mem[idx] : '0;
  assign s_rresp  = (s_rvalid && !in_win) ? RESP_DECERR : RESP_OKAY;
  assign s_rlast  = s_rvalid && at_len;
  assign ac_addr  = txn.start & ~ADDR_WIDTH'(LINE_BYTES - 1);
  assign ac_snoop = ac_valid ? SNOOP_INVALIDATE : 4'h0;

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:    if (s_awvalid) state_nx = ST_W_BURST;
                  else if (s_arvalid) state_nx = ST_R_BURST;
      ST_R_BURST: if (r_hs && at_len) state_nx = ST_IDLE;
      ST_W_BURST: if (w_hs && (s_wlast || at_len)) state_nx = snoop_en ? ST_SNOOP : ST_W_RESP;
      ST_SNOOP:   if (ac_ready) state_nx = ST_W_RESP;
      ST_W_RESP:  if (s_bready) state_nx = ST_IDLE;
      default:    state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= ST_IDLE;
      txn    <= '0;
      cnt    <= '0;
      resp_q <= RESP_OKAY;
    end else begin
      state <= state_nx;
      case (state)
        ST_IDLE: begin
          if (s_awvalid) begin
            txn    <= '{id: s_awid, addr: s_awaddr, start: s_awaddr, len: s_awlen,
                        size: s_awsize, burst: s_awburst};
            cnt    <= '0;
            resp_q <= RESP_OKAY;
          end else if (s_arvalid) begin
            txn <= '{id: s_arid, addr: s_araddr, start: s_araddr, len: s_arlen,
                     size: s_arsize, burst: s_arburst};
            cnt <= '0;
          end
        end
        ST_R_BURST: if (r_hs) begin
          txn.addr <= next_addr;
          cnt      <= cnt + 8'd1;
        end
        ST_W_BURST: if (w_hs) begin
          txn.addr <= next_addr;
          cnt      <= cnt + 8'd1;
          // DECERR is sticky and outranks a wlast/len disagreement
          if (!in_win) resp_q <= RESP_DECERR;
          else if ((s_wlast != at_len) && (resp_q != RESP_DECERR)) resp_q <= RESP_SLVERR;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && w_hs && in_win) begin
      for (int l = 0; l < NUM_LANES; l++)
        if (s_wstrb[l]) mem[idx][l] <= s_wdata[l*8 +: 8];
    end
  end

endmodule

// File: tb/tb_axi_mem_responder.sv
// Directed bench for axi_mem_responder: bursts, narrow writes, decode errors, snoop, reset.
module tb_axi_mem_responder;
  import axi_pkg::*;

  logic        clk = 1'b0, reset;
  logic [12:0] s_awid, s_bid, s_arid, s_rid;
  logic [63:0] s_awaddr, s_araddr, s_wdata, s_rdata, ac_addr;
  logic [7:0]  s_awlen, s_arlen, s_wstrb;
  logic [2:0]  s_awsize, s_arsize;
  logic [1:0]  s_awburst, s_arburst, s_bresp, s_rresp;
  logic        s_awvalid, s_awready, s_wlast, s_wvalid, s_wready, s_bvalid, s_bready;
  logic        s_arvalid, s_arready, s_rlast, s_rvalid, s_rready;
  logic [3:0]  ac_snoop;
  logic        ac_valid, ac_ready, snoop_en;

  axi_mem_responder dut (
    .clk(clk), .reset(reset),
    .s_awid(s_awid), .s_awaddr(s_awaddr), .s_awlen(s_awlen), .s_awsize(s_awsize),
    .s_awburst(s_awburst), .s_awvalid(s_awvalid), .s_awready(s_awready),
    .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wlast(s_wlast), .s_wvalid(s_wvalid),
    .s_wready(s_wready), .s_bid(s_bid), .s_bresp(s_bresp), .s_bvalid(s_bvalid),
    .s_bready(s_bready), .s_arid(s_arid), .s_araddr(s_araddr), .s_arlen(s_arlen),
    .s_arsize(s_arsize), .s_arburst(s_arburst), .s_arvalid(s_arvalid),
    .s_arready(s_arready), .s_rid(s_rid), .s_rdata(s_rdata), .s_rresp(s_rresp),
    .s_rlast(s_rlast), .s_rvalid(s_rvalid), .s_rready(s_rready),
    .ac_addr(ac_addr), .ac_snoop(ac_snoop), .ac_valid(ac_valid), .ac_ready(ac_ready),
    .snoop_en(snoop_en)
  );

  always #5 clk = ~clk;

  int          vectors = 0, miscompares = 0;
  logic [63:0] rbuf [16];
  logic [1:0]  rresp_or, wresp;
  int          nbeat;
  int          wrap_seq [8] = '{5, 6, 7, 0, 1, 2, 3, 4};

  localparam logic [12:0] RID = 13'h1a5;
  localparam logic [12:0] WID = 13'h0c3;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] pat(input int i);
    return 64'h0123_4567_0000_0000 | 64'(i);
  endfunction

  task automatic do_read(input logic [63:0] a, input logic [7:0] len, input logic [2:0] sz,
                         input logic [1:0] bst, input bit toggle);
    int          budget;
    logic [63:0] held;
    bit          stalled;
    s_arid = RID; s_araddr = a; s_arlen = len; s_arsize = sz; s_arburst = bst;
    s_arvalid = 1'b1;
    budget = 0;
    while (!s_arready && budget < 20) begin tick; budget++; end
    if (!s_arready) check("ar_timeout", 64'(s_arready), 64'd1);
    tick;
    s_arvalid = 1'b0;
    check("r_first_latency", 64'(s_rvalid), 64'd1);
    nbeat = 0; rresp_or = 2'b00; stalled = 1'b0; budget = 0;
    while (nbeat <= int'(len) && budget < 100) begin
      s_rready = toggle ? budget[0] : 1'b1;
      if (stalled) check("r_hold", s_rdata, held);
      if (s_rvalid && s_rready) begin
        rbuf[nbeat] = s_rdata;
        rresp_or |= s_rresp;
        check("rlast", 64'(s_rlast), 64'(nbeat == int'(len)));
        check("rid", 64'(s_rid), 64'(RID));
        nbeat++;
        stalled = 1'b0;
      end else if (s_rvalid) begin
        held = s_rdata;
        stalled = 1'b1;
      end
      tick;
      budget++;
    end
    s_rready = 1'b0;
    if (nbeat <= int'(len)) check("r_timeout", 64'(nbeat), 64'(len) + 64'd1);
  endtask

  task automatic do_write(input logic [63:0] a, input logic [7:0] len, input logic [2:0] sz,
                          input logic [1:0] bst, input int nbeats, input logic [7:0] strb,
                          input logic [63:0] d0, input bit snp, output logic [1:0] resp);
    int budget;
    s_awid = WID; s_awaddr = a; s_awlen = len; s_awsize = sz; s_awburst = bst;
    snoop_en = snp;
    s_awvalid = 1'b1;
    budget = 0;
    while (!s_awready && budget < 20) begin tick; budget++; end
    if (!s_awready) check("aw_timeout", 64'(s_awready), 64'd1);
    tick;
    s_awvalid = 1'b0;
    for (int i = 0; i < nbeats; i++) begin
      s_wdata = d0 + 64'(i); s_wstrb = strb; s_wlast = (i == nbeats - 1); s_wvalid = 1'b1;
      budget = 0;
      while (!s_wready && budget < 20) begin tick; budget++; end
      if (!s_wready) check("w_timeout", 64'(s_wready), 64'd1);
      tick;
    end
    s_wvalid = 1'b0; s_wlast = 1'b0;
    if (snp) begin
      check("ac_valid", 64'(ac_valid), 64'd1);
      check("ac_addr", ac_addr, a & ~64'h3f);
      check("ac_snoop", 64'(ac_snoop), 64'hd);
      check("b_before_snoop", 64'(s_bvalid), 64'd0);
      tick;
      check("ac_addr_stable", ac_addr, a & ~64'h3f);
      check("b_during_snoop", 64'(s_bvalid), 64'd0);
      ac_ready = 1'b1;
      tick;
      ac_ready = 1'b0;
    end
    check("b_latency", 64'(s_bvalid), 64'd1);
    check("bid", 64'(s_bid), 64'(WID));
    resp = s_bresp;
    s_bready = 1'b1;
    tick;
    s_bready = 1'b0;
    check("b_done", 64'(s_bvalid), 64'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    s_awid = '0; s_awaddr = '0; s_awlen = '0; s_awsize = '0; s_awburst = '0; s_awvalid = 1'b0;
    s_wdata = '0; s_wstrb = '0; s_wlast = 1'b0; s_wvalid = 1'b0; s_bready = 1'b0;
    s_arid = '0; s_araddr = '0; s_arlen = '0; s_arsize = '0; s_arburst = '0; s_arvalid = 1'b0;
    s_rready = 1'b0; ac_ready = 1'b0; snoop_en = 1'b0;
    tick; tick;
    reset = 1'b0;
    check("rst_awready", 64'(s_awready), 64'd1);
    check("rst_arready", 64'(s_arready), 64'd1);
    check("rst_wready", 64'(s_wready), 64'd0);
    check("rst_rvalid", 64'(s_rvalid), 64'd0);
    check("rst_bvalid", 64'(s_bvalid), 64'd0);
    check("rst_ac_valid", 64'(ac_valid), 64'd0);
    check("rst_rdata", s_rdata, 64'd0);
    check("rst_rid", 64'(s_rid), 64'd0);
    check("rst_bid", 64'(s_bid), 64'd0);
    check("rst_bresp", 64'(s_bresp), 64'd0);
    check("rst_rresp", 64'(s_rresp), 64'd0);
    check("rst_ac_addr", ac_addr, 64'd0);
    check("rst_ac_snoop", 64'(ac_snoop), 64'd0);

    // fill line 0x8000_0000 with pat(0..7)
    do_write(64'h8000_0000, 8'd7, 3'd3, BURST_INCR, 8, 8'hff, pat(0), 1'b0, wresp);
    check("fill_bresp", 64'(wresp), 64'd0);

    do_read(64'h8000_0028, 8'd7, 3'd3, BURST_WRAP, 1'b0);
    for (int k = 0; k < 8; k++) check("wrap_beat", rbuf[k], pat(wrap_seq[k]));
    check("wrap_rresp", 64'(rresp_or), 64'd0);
    check("wrap_idle", 64'(s_arready), 64'd1);

    do_write(64'h8000_0040, 8'd7, 3'd3, BURST_INCR, 8, 8'hff, 64'hfeed_0000_0000_0000, 1'b1, wresp);
    check("snoop_bresp", 64'(wresp), 64'd0);
    do_read(64'h8000_0040, 8'd7, 3'd3, BURST_INCR, 1'b0);
    for (int k = 0; k < 8; k++) check("incr_readback", rbuf[k], 64'hfeed_0000_0000_0000 + 64'(k));

    do_write(64'h8000_0003, 8'd0, 3'd0, BURST_INCR, 1, 8'h08, 64'h0000_0000_aa00_0000, 1'b0, wresp);
    check("byte_bresp", 64'(wresp), 64'd0);
    do_read(64'h8000_0000, 8'd0, 3'd3, BURST_INCR, 1'b0);
    check("byte_merge", rbuf[0], 64'h0123_4567_aa00_0000);

    do_read(64'h1000_0000, 8'd0, 3'd3, BURST_INCR, 1'b0);
    check("low_rdata", rbuf[0], 64'd0);
    check("low_rresp", 64'(rresp_or), 64'd3);
    do_write(64'h1000_0000, 8'd0, 3'd3, BURST_INCR, 1, 8'hff, 64'hdead_beef_dead_beef, 1'b0, wresp);
    check("low_bresp", 64'(wresp), 64'd3);
    do_read(64'h8000_0000, 8'd0, 3'd3, BURST_INCR, 1'b0);
    check("low_no_alias", rbuf[0], 64'h0123_4567_aa00_0000);
    do_read(64'h8000_8000, 8'd0, 3'd3, BURST_INCR, 1'b0);
    check("high_rresp", 64'(rresp_or), 64'd3);

    // wlast on beat 1 of a 4-beat burst
    do_write(64'h8000_0100, 8'd3, 3'd3, BURST_INCR, 2, 8'hff, 64'h5, 1'b0, wresp);
    check("early_wlast_bresp", 64'(wresp), 64'd2);

    // simultaneous AW/AR: write first, read sees the new data
    s_arid = RID; s_araddr = 64'h8000_0008; s_arlen = 8'd1; s_arsize = 3'd3;
    s_arburst = BURST_INCR; s_arvalid = 1'b1;
    s_awid = WID; s_awaddr = 64'h8000_0008; s_awlen = 8'd0; s_awsize = 3'd3;
    s_awburst = BURST_INCR; s_awvalid = 1'b1;
    #1;
    check("both_awready", 64'(s_awready), 64'd1);
    check("both_arready", 64'(s_arready), 64'd0);
    do_write(64'h8000_0008, 8'd0, 3'd3, BURST_INCR, 1, 8'hff, 64'hc0ff_ee00_0000_0001, 1'b0, wresp);
    check("both_bresp", 64'(wresp), 64'd0);
    do_read(64'h8000_0008, 8'd1, 3'd3, BURST_INCR, 1'b1);
    check("both_beat0", rbuf[0], 64'hc0ff_ee00_0000_0001);
    check("both_beat1", rbuf[1], pat(2));

    // reset while beat 4 of an 8-beat read is on the bus
    s_arid = RID; s_araddr = 64'h8000_0000; s_arlen = 8'd7; s_arsize = 3'd3;
    s_arburst = BURST_INCR; s_arvalid = 1'b1;
    tick;
    s_arvalid = 1'b0; s_rready = 1'b1;
    tick; tick; tick;
    check("rst_mid_beat4", s_rdata, pat(3));
    check("rst_mid_rvalid_pre", 64'(s_rvalid), 64'd1);
    reset = 1'b1;
    tick;
    check("rst_mid_rvalid", 64'(s_rvalid), 64'd0);
    reset = 1'b0;
    s_rready = 1'b0;
    check("rst_mid_awready", 64'(s_awready), 64'd1);
    check("rst_mid_arready", 64'(s_arready), 64'd1);
    tick;
    check("rst_mid_no_r", 64'(s_rvalid), 64'd0);
    check("rst_mid_no_b", 64'(s_bvalid), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
